// File: rtl/disp_arbiter.sv
// disp_arbiter: shares the 32-bit 7-segment display word among NREQ requesters.
// A winner owns the display for at least HOLD_CYCLES cycles.
// The owner may refresh its word at any time during its dwell.
// Every accepted word is acknowledged with a one-cycle req_ack pulse.
// Optional macro DISP_ARB_RR_EN selects round-robin arbitration.
// When it is undefined, arbitration is fixed priority and the lowest index wins.
module disp_arbiter #(
    parameter int unsigned NREQ        = 3,
    parameter int unsigned HOLD_CYCLES = 100_000_000,
    parameter logic [31:0] IDLE_VALUE  = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ack,
    output logic [31:0]          disp_data,
    output logic [2:0]           disp_owner,
    output logic                 disp_busy
);

    localparam int unsigned     IDXW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [31:0]     LAST_CNT = 32'(HOLD_CYCLES - 1);
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [31:0]       data_q, data_d;
    logic [2:0]        owner_q, owner_d;

    logic [31:0]       req_word [NREQ];
    logic [NREQ-1:0]   eligible;
    logic [NREQ-1:0]   owner_mask;
    logic [NREQ-1:0]   cand;
    logic [IDXW-1:0]   owner_idx;
    logic [IDXW-1:0]   win_idx;
    logic              win_found;
    logic              expiry;

`ifdef DISP_ARB_RR_EN
    logic [IDXW-1:0]   rr_ptr_q, rr_ptr_d;
    int unsigned       rr_idx;
`endif

    for (genvar g = 0; g < NREQ; g++) begin : g_words
        assign req_word[g] = req_data[32*g +: 32];
    end

    // A requester is ineligible during its own ack cycle, so a held-high valid is not accepted twice.
    assign eligible   = req_valid & ~ack_q;
    assign owner_idx  = owner_q[IDXW-1:0];
    assign owner_mask = ONE_HOT0 << owner_idx;
    assign expiry     = (state_q == ST_HOLD) && (cnt_q == LAST_CNT);
    assign cand       = (state_q == ST_IDLE) ? eligible : (eligible & ~owner_mask);

    // Pick a winner from the candidate set; at dwell expiry the owner is excluded from the candidates.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
`ifdef DISP_ARB_RR_EN
        rr_idx    = 0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            rr_idx = (32'(rr_ptr_q) + off) % NREQ;
            if (!win_found && cand[IDXW'(rr_idx)]) begin
                win_found = 1'b1;
                win_idx   = IDXW'(rr_idx);
            end
        end
`else
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (cand[IDXW'(i)]) begin
                win_found = 1'b1;
                win_idx   = IDXW'(i);
            end
        end
`endif
    end

    // Next-state logic: grant from IDLE, owner refresh and dwell expiry while in HOLD.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ack_d    = '0;
        data_d   = data_q;
        owner_d  = owner_q;
`ifdef DISP_ARB_RR_EN
        rr_ptr_d = rr_ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    data_d  = req_word[win_idx];
                    ack_d   = ONE_HOT0 << win_idx;
                    owner_d = 3'(win_idx);
                    cnt_d   = '0;
                    state_d = ST_HOLD;
`ifdef DISP_ARB_RR_EN
                    rr_ptr_d = IDXW'((32'(win_idx) + 1) % NREQ);
`endif
                end
            end
            ST_HOLD: begin
                if (cnt_q != LAST_CNT) begin
                    cnt_d = cnt_q + 32'd1;
                end
                if ((eligible & owner_mask) != '0) begin
                    data_d = req_word[owner_idx];
                    ack_d  = owner_mask;
                end
                if (expiry) begin
                    if (win_found) begin
                        data_d  = req_word[win_idx];
                        ack_d   = ONE_HOT0 << win_idx;
                        owner_d = 3'(win_idx);
                        cnt_d   = '0;
`ifdef DISP_ARB_RR_EN
                        rr_ptr_d = IDXW'((32'(win_idx) + 1) % NREQ);
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset drops every pending request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            ack_q    <= '0;
            data_q   <= IDLE_VALUE;
            owner_q  <= '0;
`ifdef DISP_ARB_RR_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            data_q   <= data_d;
            owner_q  <= owner_d;
`ifdef DISP_ARB_RR_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    assign req_ack    = ack_q;
    assign disp_data  = data_q;
    assign disp_owner = owner_q;
    assign disp_busy  = (state_q == ST_HOLD);

endmodule

// File: doc/disp_arbiter.md
# disp_arbiter

Shares the single 32-bit 7-segment display word among `NREQ` requesters, e.g. CPU MMIO store, PC/debug tracer and switch echo. It sits directly in front of the display scanner and drives the scanner's 32-bit `data` input. It grants ownership for a minimum dwell time so every value stays readable. It acknowledges each accepted word and retains the last shown value when no requester is active.

## Interface
- `NREQ`, default 3: number of requesters, range 2–8.
- `HOLD_CYCLES`, default 100_000_000: minimum dwell per grant, in clk cycles (1 s at 100 MHz). Must be ≥1.
- `IDLE_VALUE`, default 32'h0000_0000: display word after reset.
- `clk` in 1: system clock, 100 MHz.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in NREQ: bit i high means requester i has a word to show. It stays high until acked.
- `req_data` in 32*NREQ: requester i's word is at bits [32*i+31:32*i].
- `req_ack` out NREQ: one-cycle pulse; bit i high means requester i's word was latched.
- `disp_data` out 32: word to the scanner.
- `disp_owner` out 3: index of the current or most recent owner.
- `disp_busy` out 1: high while in HOLD.

## Operation
- Reset values:
  - `disp_data` = IDLE_VALUE.
  - `req_ack` = 0, `disp_owner` = 0, `disp_busy` = 0.
  - State IDLE, dwell counter = 0, round-robin pointer = 0 (index 0 has highest priority).
- Eligible set: `req_valid & ~req_ack`. A requester is ineligible in its own ack cycle, so a held-high valid is not double-accepted.
- **IDLE:** if the eligible set is non-empty, arbitrate. On that edge:
  - Latch the winner's data into `disp_data`.
  - Pulse `req_ack[winner]` and set `disp_owner` = winner.
  - Clear the counter and go to HOLD.
  - With no requester pending, stay in IDLE; `disp_data` keeps its last value.
- **HOLD:** the counter increments every cycle.
  - Owner refresh: if the owner is eligible, latch its data and ack it immediately. The counter is not restarted.
  - Non-owner requests stay pending with no ack. Requesters must hold `req_valid` and `req_data` stable until acked.
- **Dwell expiry** (counter == HOLD_CYCLES-1):
  - If any non-owner is eligible, arbitrate among non-owners only. Grant as above, clear the counter, stay in HOLD.
  - Otherwise go to IDLE.
  - If the owner refresh and the switch fall on the same edge, the switch wins and the owner is not acked.
- **Arbitration:**
  - Fixed priority: the lowest index wins.
  - Round-robin: see Configuration.
- `disp_busy` = (state == HOLD).
- Counter width is 32 bits, with no wrap: it stops at HOLD_CYCLES-1.
- Asynchronous reset mid-HOLD immediately restores all reset values. Pending requests are dropped and must be re-presented (`req_valid` still high after reset counts as a new request).

## Timing
- All outputs are registered.
- A request sampled at edge k produces `disp_data`, `req_ack` and `disp_owner` valid after edge k: 1-cycle latency from IDLE.
- `req_ack` is high exactly one cycle per accepted word.
- The minimum interval between grants to different owners is HOLD_CYCLES cycles.
- Owner refresh has 1-cycle latency at any point in HOLD.
- The scanner shows a new word within one full scan (≤16 ms).

## Configuration
- Macro: `DISP_ARB_RR_EN`.
- Defined: round-robin. The search starts at pointer. On each grant, pointer = (winner+1) mod NREQ.
- Undefined: fixed priority, lowest eligible index wins. The pointer logic is not compiled.

## Test plan
All scenarios use NREQ=3, HOLD_CYCLES=4, IDLE_VALUE=32'hDEAD_0000.
- Reset applied and held: `disp_data`=DEAD0000, `req_ack`=000, `disp_owner`=0, `disp_busy`=0.
- Single request: `req_valid[0]`=1 with 12345678 at edge k.
  - After edge k: `disp_data`=12345678, `req_ack`=001 for one cycle, `busy`=1.
  - Valid dropped: `busy`=0 after edge k+4, `disp_data` still 12345678.
- Contention: req0 is owner; `req_valid[2]` rises at k+1 with CAFEF00D.
  - No ack[2] through edge k+3.
  - At edge k+4: `disp_data`=CAFEF00D, `ack`=100, `owner`=2.
- Round-robin fairness: req0 and req1 both held high and re-present after each ack.
  - `DISP_ARB_RR_EN` defined: owners alternate 0,1,0,1 every 4 cycles.
  - Macro undefined: owner 0 stays for its dwell; req1 is granted only at each expiry (0 is excluded as the owner at expiry).
- Owner refresh: req0 owner, new word 0000_00AA at k+2.
  - `disp_data`=000000AA after k+2, ack[0] pulses.
  - Dwell still expires at k+4.
- Async reset asserted at k+2 of HOLD with req1 pending: outputs immediately at reset values, no ack.
  - After release with `req_valid[1]` still high: req1 is granted on the first edge.
